// File: rtl/dm_responder.sv
// Data-memory responder for the core's load/store port: word requests are answered
// after LATENCY wait cycles, with byte-enabled stores and an access error flag.
module dm_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [3:0]       req_be,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
  localparam logic [3:0]  LAT_M1    = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;
  logic [31:0]      mem_q [DEPTH];

  logic             accept;
  logic             enter_resp;
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [3:0]       cur_be;
  logic [31:0]      cur_wdata;
  logic             acc_err;
  logic [AW-1:0]    idx;

  assign accept = req_valid && (state_q == IDLE);

  // With zero latency the access completes on the accept edge, so use the live request.
  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_be    = (state_q == IDLE) ? req_be    : be_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  assign acc_err = (cur_addr[1:0] != 2'b00) || (cur_addr >= MEM_BYTES);
  assign idx     = cur_addr[AW+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
      // Stores commit here, before the response, so a following load sees them.
      if (enter_resp) begin
        err_q <= acc_err;
        if (acc_err) begin
          rdata_q <= 32'd0;
        end else if (cur_we) begin
          rdata_q <= 32'd0;
          for (int b = 0; b < 4; b++) begin
            if (cur_be[b]) mem_q[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
          end
        end else begin
          rdata_q <= mem_q[idx];
        end
      end
      if (state_q == RESP && resp_ready) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
        if (!err_q) begin
          if (we_q) begin
            if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
          end else begin
            if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=2 instance for functional checks and a
// LATENCY=0, CNT_W=4 instance for throughput and counter saturation.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqReady, reqWe;
  logic [31:0] reqAddr, reqWdata;
  logic [3:0]  reqBe;
  logic        respValid, respReady, respErr;
  logic [31:0] respRdata;
  logic [15:0] rdCount, wrCount;

  logic        bReqValid, bReqReady, bRespValid, bRespErr;
  logic [31:0] bRespRdata;
  logic [3:0]  bRdCount, bWrCount;

  int checkCount = 0;
  int errCount   = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(1024), .LATENCY(2), .CNT_W(16)) dutA (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
    .req_addr(reqAddr), .req_be(reqBe), .req_wdata(reqWdata),
    .resp_valid(respValid), .resp_ready(respReady),
    .resp_rdata(respRdata), .resp_err(respErr),
    .rd_count(rdCount), .wr_count(wrCount)
  );

  dm_responder #(.DEPTH(1024), .LATENCY(0), .CNT_W(4)) dutB (
    .clk(clk), .reset(reset),
    .req_valid(bReqValid), .req_ready(bReqReady), .req_we(1'b0),
    .req_addr(32'h0000_0008), .req_be(4'hF), .req_wdata(32'h0),
    .resp_valid(bRespValid), .resp_ready(1'b1),
    .resp_rdata(bRespRdata), .resp_err(bRespErr),
    .rd_count(bRdCount), .wr_count(bWrCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // One transaction on dutA; optionally holds off the response for 'hold' cycles
  // while presenting a junk store that must not be accepted.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata, input int hold,
                               input logic [31:0] expRdata, input logic expErr);
    int n;
    @(negedge clk);
    n = 0;
    while (!reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_reqReady"}, 32'(reqReady), 32'd1);
    reqValid = 1'b1;
    reqWe    = we;
    reqAddr  = addr;
    reqBe    = be;
    reqWdata = wdata;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    reqWe    = 1'b0;
    reqAddr  = 32'hFFFF_FFFC;
    n = 0;
    while (!respValid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd2);
    for (int i = 0; i < hold; i++) begin
      reqValid = 1'b1;
      reqWe    = 1'b1;
      reqAddr  = 32'h0000_0010;
      reqBe    = 4'hF;
      reqWdata = 32'h0BAD_0BAD;
      @(negedge clk);
      checkOutput({tag, "_holdValid"}, 32'(respValid), 32'd1);
      checkOutput({tag, "_holdRdata"}, respRdata, expRdata);
      checkOutput({tag, "_holdReqReady"}, 32'(reqReady), 32'd0);
    end
    reqValid = 1'b0;
    reqWe    = 1'b0;
    checkOutput({tag, "_rdata"}, respRdata, expRdata);
    checkOutput({tag, "_err"}, 32'(respErr), 32'(expErr));
    respReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    respReady = 1'b0;
    checkOutput({tag, "_idleReady"}, 32'(reqReady), 32'd1);
    checkOutput({tag, "_validDrop"}, 32'(respValid), 32'd0);
    checkOutput({tag, "_rdataClr"}, respRdata, 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int  nResp;
    int  firstResp;
    bit  sawValid;
    reset     = 1'b1;
    reqValid  = 1'b0;
    reqWe     = 1'b0;
    reqAddr   = 32'h0;
    reqBe     = 4'h0;
    reqWdata  = 32'h0;
    respReady = 1'b0;
    bReqValid = 1'b0;
    doReset();

    checkOutput("rstReqReady", 32'(reqReady), 32'd1);
    checkOutput("rstRespValid", 32'(respValid), 32'd0);
    checkOutput("rstRdata", respRdata, 32'd0);
    checkOutput("rstErr", 32'(respErr), 32'd0);
    checkOutput("rstRdCount", 32'(rdCount), 32'd0);
    checkOutput("rstWrCount", 32'(wrCount), 32'd0);

    applyStimulus("st10", 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    applyStimulus("ld10", 1'b0, 32'h10, 4'h0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    checkOutput("cntWr1", 32'(wrCount), 32'd1);
    checkOutput("cntRd1", 32'(rdCount), 32'd1);

    applyStimulus("st20", 1'b1, 32'h20, 4'hF, 32'h1122_3344, 0, 32'h0, 1'b0);
    applyStimulus("st20be", 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 0, 32'h0, 1'b0);
    applyStimulus("ld20", 1'b0, 32'h20, 4'h0, 32'h0, 0, 32'h11BB_33DD, 1'b0);
    applyStimulus("st20be0", 1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, 0, 32'h0, 1'b0);
    applyStimulus("ld20b", 1'b0, 32'h20, 4'h0, 32'h0, 0, 32'h11BB_33DD, 1'b0);
    checkOutput("cntWr4", 32'(wrCount), 32'd4);
    checkOutput("cntRd3", 32'(rdCount), 32'd3);

    applyStimulus("bpLd10", 1'b0, 32'h10, 4'h0, 32'h0, 5, 32'hDEAD_BEEF, 1'b0);
    applyStimulus("ld10b", 1'b0, 32'h10, 4'h0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    checkOutput("cntWrBp", 32'(wrCount), 32'd4);
    checkOutput("cntRdBp", 32'(rdCount), 32'd5);

    applyStimulus("errMis", 1'b0, 32'h2, 4'h0, 32'h0, 0, 32'h0, 1'b1);
    applyStimulus("errRange", 1'b1, 32'h1000, 4'hF, 32'h1234_5678, 0, 32'h0, 1'b1);
    checkOutput("cntWrErr", 32'(wrCount), 32'd4);
    checkOutput("cntRdErr", 32'(rdCount), 32'd5);
    applyStimulus("ld0", 1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    checkOutput("cntRd6", 32'(rdCount), 32'd6);

    // Store accepted, then reset lands while it is still waiting.
    @(negedge clk);
    reqValid = 1'b1;
    reqWe    = 1'b1;
    reqAddr  = 32'h40;
    reqBe    = 4'hF;
    reqWdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    reqWe    = 1'b0;
    checkOutput("midWaitReady", 32'(reqReady), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (respValid) sawValid = 1'b1;
      @(negedge clk);
    end
    checkOutput("midRstNoResp", 32'(sawValid), 32'd0);
    checkOutput("midRstRd", 32'(rdCount), 32'd0);
    checkOutput("midRstWr", 32'(wrCount), 32'd0);
    applyStimulus("ld40", 1'b0, 32'h40, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    applyStimulus("ld10clr", 1'b0, 32'h10, 4'h0, 32'h0, 0, 32'h0, 1'b0);

    // Zero-latency instance: continuous loads, resp_ready tied high.
    doReset();
    checkOutput("bRstRd", 32'(bRdCount), 32'd0);
    @(negedge clk);
    bReqValid = 1'b1;
    nResp     = 0;
    firstResp = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bRespValid) begin
        if (firstResp < 0) firstResp = i;
        nResp++;
        checkOutput("bRdata", bRespRdata, 32'd0);
      end
      if (i == 9) checkOutput("bRdMid", 32'(bRdCount), 32'd5);
    end
    bReqValid = 1'b0;
    checkOutput("bFirstResp", 32'(firstResp), 32'd0);
    checkOutput("bRespCount", 32'(nResp), 32'd20);
    checkOutput("bRdSat", 32'(bRdCount), 32'd15);
    checkOutput("bWr", 32'(bWrCount), 32'd0);
    checkOutput("bErr", 32'(bRespErr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
